// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and the
// instruction register, ALU and memory side of the datapath (slave).
interface multicycle_controller_if #(
  parameter int unsigned INSTRET_W = 32
);
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic                 alu_zero;
  logic                 imem_ready;
  logic                 dmem_ready;

  logic                 imem_req;
  logic                 dmem_req;
  logic                 ir_write;
  logic                 pc_write;
  logic [1:0]           pc_source;
  logic                 reg_write_enable;
  logic                 mem_write_enable;
  logic [1:0]           alu_source;
  logic [1:0]           reg_write_source;
  logic [1:0]           bit_half_word_select;
  logic                 is_unsigned;
  logic [2:0]           imm_op;
  logic [3:0]           alu_op;
  logic                 trap;
  logic [1:0]           trap_cause;
  logic [INSTRET_W-1:0] instret;
  logic [2:0]           state;

  modport master (
    input  opcode, funct3, funct7, alu_zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, ir_write, pc_write, pc_source,
           reg_write_enable, mem_write_enable, alu_source, reg_write_source,
           bit_half_word_select, is_unsigned, imm_op, alu_op,
           trap, trap_cause, instret, state
  );

  modport slave (
    output opcode, funct3, funct7, alu_zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, ir_write, pc_write, pc_source,
           reg_write_enable, mem_write_enable, alu_source, reg_write_source,
           bit_half_word_select, is_unsigned, imm_op, alu_op,
           trap, trap_cause, instret, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with bus-timeout,
// illegal-instruction and ECALL/EBREAK traps and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;
  localparam logic [1:0] CAUSE_ECALL   = 2'b11;

  // Counter only needs to reach TIMEOUT-1: the limit cycle itself is the last wait.
  localparam int unsigned   CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);

  state_t               r_state;
  logic [CNT_W-1:0]     r_wait_cnt;
  logic [INSTRET_W-1:0] r_instret;
  logic [1:0]           r_trap_cause;

  logic       w_is_r, w_is_imm, w_is_load, w_is_store, w_is_branch;
  logic       w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_system;
  logic       w_legal, w_taken, w_retire, w_wait_expired, w_dec_active;
  logic [3:0] w_arith_op;
  logic [1:0] w_alu_source, w_pc_source, w_reg_write_source, w_bhw;
  logic       w_is_unsigned;
  logic [2:0] w_imm_op;
  logic [3:0] w_alu_op;

  assign w_is_r      = (bus.opcode == OP_R);
  assign w_is_imm    = (bus.opcode == OP_IMM);
  assign w_is_load   = (bus.opcode == OP_LOAD);
  assign w_is_store  = (bus.opcode == OP_STORE);
  assign w_is_branch = (bus.opcode == OP_BRANCH);
  assign w_is_lui    = (bus.opcode == OP_LUI);
  assign w_is_auipc  = (bus.opcode == OP_AUIPC);
  assign w_is_jal    = (bus.opcode == OP_JAL);
  assign w_is_jalr   = (bus.opcode == OP_JALR);
  assign w_is_system = (bus.opcode == OP_SYSTEM);

  // BEQ/BGE/BGEU branch on a zero compare result, the others on non-zero.
  assign w_taken = bus.alu_zero ^ (bus.funct3[0] ^ bus.funct3[2]);

  assign w_wait_expired = TIMEOUT_EN && (r_wait_cnt == CNT_LIMIT);

  assign w_retire = ((r_state == S_EXEC) && w_is_branch)
                 || ((r_state == S_MEM) && w_is_store && bus.dmem_ready)
                 || (r_state == S_WB);

  assign w_dec_active = (r_state == S_DECODE) || (r_state == S_EXEC)
                     || (r_state == S_MEM)    || (r_state == S_WB);

  always_comb begin
    w_arith_op = ALU_ADD;
    case (bus.funct3)
      3'b000:  w_arith_op = (w_is_r && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_arith_op = ALU_SLL;
      3'b010:  w_arith_op = ALU_SLT;
      3'b011:  w_arith_op = ALU_SLTU;
      3'b100:  w_arith_op = ALU_XOR;
      3'b101:  w_arith_op = bus.funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  w_arith_op = ALU_OR;
      default: w_arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    if (w_is_r) begin
      w_legal = (bus.funct7 == 7'b0000000)
             || ((bus.funct7 == 7'b0100000)
                 && ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)));
    end else if (w_is_imm) begin
      if (bus.funct3 == 3'b001)
        w_legal = (bus.funct7 == 7'b0000000);
      else if (bus.funct3 == 3'b101)
        w_legal = (bus.funct7 == 7'b0000000) || (bus.funct7 == 7'b0100000);
      else
        w_legal = 1'b1;
    end else if (w_is_load) begin
      w_legal = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b110)
             && (bus.funct3 != 3'b111);
    end else if (w_is_store) begin
      w_legal = !bus.funct3[2] && (bus.funct3[1:0] != 2'b11);
    end else if (w_is_branch) begin
      w_legal = (bus.funct3[2:1] != 2'b01);
    end else if (w_is_lui || w_is_auipc || w_is_jal) begin
      w_legal = 1'b1;
    end else if (w_is_jalr) begin
      w_legal = (bus.funct3 == 3'b000);
    end
  end

  always_comb begin
    w_alu_source       = 2'b00;
    w_pc_source        = 2'b00;
    w_reg_write_source = 2'b00;
    w_bhw              = 2'b00;
    w_is_unsigned      = 1'b0;
    w_imm_op           = 3'b000;
    w_alu_op           = ALU_ADD;
    if (w_is_r) begin
      w_alu_op = w_arith_op;
    end else if (w_is_imm) begin
      w_alu_source = 2'b01;
      w_alu_op     = w_arith_op;
    end else if (w_is_load) begin
      w_alu_source       = 2'b01;
      w_bhw              = bus.funct3[1:0];
      w_is_unsigned      = bus.funct3[2];
      w_reg_write_source = 2'b01;
    end else if (w_is_store) begin
      w_alu_source = 2'b01;
      w_imm_op     = 3'b001;
      w_bhw        = bus.funct3[1:0];
    end else if (w_is_branch) begin
      w_imm_op    = 3'b010;
      w_alu_op    = bus.funct3[2] ? (bus.funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      w_pc_source = w_taken ? 2'b01 : 2'b00;
    end else if (w_is_lui) begin
      w_alu_source = 2'b01;
      w_imm_op     = 3'b011;
      w_alu_op     = ALU_PASSB;
    end else if (w_is_auipc) begin
      w_alu_source = 2'b10;
      w_imm_op     = 3'b011;
    end else if (w_is_jal) begin
      w_alu_source       = 2'b10;
      w_imm_op           = 3'b100;
      w_reg_write_source = 2'b10;
      w_pc_source        = 2'b01;
    end else if (w_is_jalr) begin
      w_alu_source       = 2'b01;
      w_reg_write_source = 2'b10;
      w_pc_source        = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_instret    <= '0;
      r_trap_cause <= 2'b00;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.imem_ready) begin
            r_state    <= S_DECODE;
            r_wait_cnt <= '0;
          end else if (w_wait_expired) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_BUS;
            r_wait_cnt   <= '0;
          end else if (TIMEOUT_EN) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          r_wait_cnt <= '0;
          if (w_is_system) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_ECALL;
          end else if (!w_legal) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_ILLEGAL;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wait_cnt <= '0;
          if (w_is_load || w_is_store) r_state <= S_MEM;
          else if (w_is_branch)        r_state <= S_FETCH;
          else                         r_state <= S_WB;
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            r_state    <= w_is_load ? S_WB : S_FETCH;
            r_wait_cnt <= '0;
          end else if (w_wait_expired) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_BUS;
            r_wait_cnt   <= '0;
          end else if (TIMEOUT_EN) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          r_state    <= S_FETCH;
          r_wait_cnt <= '0;
        end
        S_TRAP: begin
          r_state <= S_TRAP;
        end
        default: begin
          r_state    <= S_FETCH;
          r_wait_cnt <= '0;
        end
      endcase
      if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  // Outputs are forced quiet while rst is asserted, even before the reset edge.
  assign bus.state = rst ? 3'b000 : r_state;

  always_comb begin
    bus.imem_req             = 1'b0;
    bus.dmem_req             = 1'b0;
    bus.ir_write             = 1'b0;
    bus.pc_write             = 1'b0;
    bus.reg_write_enable     = 1'b0;
    bus.mem_write_enable     = 1'b0;
    bus.pc_source            = 2'b00;
    bus.alu_source           = 2'b00;
    bus.reg_write_source     = 2'b00;
    bus.bit_half_word_select = 2'b00;
    bus.is_unsigned          = 1'b0;
    bus.imm_op               = 3'b000;
    bus.alu_op               = 4'b0000;
    bus.trap                 = 1'b0;
    bus.trap_cause           = 2'b00;
    bus.instret              = '0;
    if (!rst) begin
      bus.trap       = (r_state == S_TRAP);
      bus.trap_cause = r_trap_cause;
      bus.instret    = r_instret;
      if (w_dec_active) begin
        bus.pc_source            = w_pc_source;
        bus.alu_source           = w_alu_source;
        bus.reg_write_source     = w_reg_write_source;
        bus.bit_half_word_select = w_bhw;
        bus.is_unsigned          = w_is_unsigned;
        bus.imm_op               = w_imm_op;
        bus.alu_op               = w_alu_op;
      end
      case (r_state)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_write = bus.imem_ready;
        end
        S_EXEC: begin
          bus.pc_write = w_is_branch;
        end
        S_MEM: begin
          bus.dmem_req         = 1'b1;
          bus.mem_write_enable = w_is_store;
          bus.pc_write         = w_is_store && bus.dmem_ready;
        end
        S_WB: begin
          bus.reg_write_enable = 1'b1;
          bus.pc_write         = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
